// File: rtl/coord_scan_gen.sv
// Frame-scan coordinate generator: sweeps an H_RES x V_RES frame and streams one (re, im) per pixel.
// Optional build macro COORD_SCAN_CENTER_EN: start_re/start_im give the frame centre instead of pixel (0,0).
module coord_scan_gen #(
    parameter int Q           = 21,
    parameter int N           = 32,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int ZW          = 2,
    parameter int STEP0_SHIFT = 8,
    parameter int ZOOM_SHIFT  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [N-1:0]  start_re_i,
    input  logic [N-1:0]  start_im_i,
    input  logic [ZW-1:0] zoom_level_i,
    output logic          busy_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [N-1:0]  out_re_o,
    output logic [N-1:0]  out_im_o,
    output logic [XW-1:0] out_x_o,
    output logic [YW-1:0] out_y_o,
    output logic          out_eol_o,
    output logic          out_last_o,
    output logic [1:0]    state_o
);

    // Stream handshake: a pixel transfers on a rising edge where out_valid_o && out_ready_i;
    // while out_valid_o is high and out_ready_i is low every out_* signal holds stable.

    if (Q < STEP0_SHIFT + ZOOM_SHIFT * ((1 << ZW) - 1)) begin : g_step_range_check
        $error("coord_scan_gen: Q too small for the deepest zoom level");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  H_HALF = N'(H_RES / 2);
    localparam logic [N-1:0]  V_HALF = N'(V_RES / 2);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  cre_q, cre_d, cim_q, cim_d;
    logic [ZW-1:0] zoom_q, zoom_d;
    logic [N-1:0]  step_q, step_d, re0_q, re0_d;
    logic [N-1:0]  re_q, re_d, im_q, im_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic [31:0]   step_sh;
    logic [N-1:0]  step_w, re0_w, im0_w;
    logic          eol_w, last_w, run_w;

    // Step is a power of two, so the centre offsets are plain shifts of constants.
    always_comb begin
        step_sh = 32'(Q - STEP0_SHIFT) - 32'(ZOOM_SHIFT) * 32'(zoom_q);
        step_w  = ONE << step_sh;
`ifdef COORD_SCAN_CENTER_EN
        re0_w   = cre_q - (H_HALF << step_sh);
        im0_w   = cim_q + (V_HALF << step_sh);
`else
        re0_w   = cre_q;
        im0_w   = cim_q;
`endif
    end

    assign run_w  = (state_q == S_RUN);
    assign eol_w  = (x_q == X_LAST);
    assign last_w = eol_w && (y_q == Y_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cre_q   <= '0;
            cim_q   <= '0;
            zoom_q  <= '0;
            step_q  <= '0;
            re0_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cre_q   <= cre_d;
            cim_q   <= cim_d;
            zoom_q  <= zoom_d;
            step_q  <= step_d;
            re0_q   <= re0_d;
            re_q    <= re_d;
            im_q    <= im_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cre_d   = cre_q;
        cim_d   = cim_q;
        zoom_d  = zoom_q;
        step_d  = step_q;
        re0_d   = re0_q;
        re_d    = re_q;
        im_d    = im_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cre_d   = start_re_i;
                    cim_d   = start_im_i;
                    zoom_d  = zoom_level_i;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                step_d  = step_w;
                re0_d   = re0_w;
                re_d    = re0_w;
                im_d    = im0_w;
                x_d     = '0;
                y_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (out_ready_i) begin
                    if (last_w) begin
                        state_d = S_IDLE;
                    end else if (eol_w) begin
                        x_d  = '0;
                        y_d  = y_q + YW'(1);
                        re_d = re0_q;
                        im_d = im_q - step_q;
                    end else begin
                        x_d  = x_q + XW'(1);
                        re_d = re_q + step_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = run_w;
    assign out_re_o    = re_q;
    assign out_im_o    = im_q;
    assign out_x_o     = x_q;
    assign out_y_o     = y_q;
    assign out_eol_o   = run_w && eol_w;
    assign out_last_o  = run_w && last_w;
    assign state_o     = state_q;

endmodule

// File: tb/tb_coord_scan_gen.sv
// Scoreboard bench for coord_scan_gen on a 4x3 frame; a negedge monitor pops expected pixels.
module tb_coord_scan_gen;
    localparam int N  = 32;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int ZW = 2;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int W  = 2 * N + XW + YW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  start_re = '0;
    logic [N-1:0]  start_im = '0;
    logic [ZW-1:0] zoom = '0;
    logic          out_ready = 1'b1;
    logic          busy, out_valid, out_eol, out_last;
    logic [N-1:0]  out_re, out_im;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [1:0]    state;

    coord_scan_gen #(.H_RES(H), .V_RES(V)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_re_i(start_re),
        .start_im_i(start_im), .zoom_level_i(zoom), .busy_o(busy),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_re_o(out_re),
        .out_im_o(out_im), .out_x_o(out_x), .out_y_o(out_y), .out_eol_o(out_eol),
        .out_last_o(out_last), .state_o(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [W-1:0] exp_q[$];
    logic [N-1:0] cap_re[0:H*V-1];
    logic [N-1:0] cap_im[0:H*V-1];
    logic         stall_prev = 1'b0;
    logic         last_prev  = 1'b0;
    logic [W-1:0] stall_word;
    wire  [W-1:0] dut_word = {out_re, out_im, out_x, out_y, out_eol, out_last};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected pixels come from the closed-form mapping re0 + x*step, im0 - y*step.
    task automatic push_frame(input logic [N-1:0] re0, input logic [N-1:0] im0, input logic [N-1:0] step);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                logic [N-1:0] r, i;
                r = re0 + N'(x) * step;
                i = im0 - N'(y) * step;
                exp_q.push_back({r, i, XW'(x), YW'(y), (x == H - 1), (x == H - 1) && (y == V - 1)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (stall_prev && out_valid) check("stall_hold", dut_word, stall_word);
            if (last_prev) check("end_drop", {out_valid, busy}, 2'b00);
            last_prev = 1'b0;
            if (out_valid && out_ready) begin
                int idx;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got pixel (%0d,%0d) expected none", out_x, out_y);
                end else begin
                    check("beat", dut_word, exp_q.pop_front());
                end
                idx = int'(out_y) * H + int'(out_x);
                if (idx < H * V) begin
                    cap_re[idx] = out_re;
                    cap_im[idx] = out_im;
                end
                beats++;
                last_prev = out_last;
            end
            stall_prev = out_valid && !out_ready;
            stall_word = dut_word;
        end
    end

    task automatic start_frame(input logic [N-1:0] re, input logic [N-1:0] im, input logic [ZW-1:0] z);
        beats = 0;
        @(posedge clk); #1;
        start = 1'b1; start_re = re; start_im = im; zoom = z;
        @(posedge clk); #1;
        start = 1'b0;
        check("setup_cycle", {busy, out_valid}, 2'b10);
        start_re = $urandom; start_im = $urandom; zoom = ZW'($urandom_range(0, 3));
        @(posedge clk); #1;
        check("latency_valid", out_valid, 1'b1);
    endtask

    task automatic frame_end(input string name, input int exp_beats);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 200 cycles", name);
        end
        @(posedge clk); #1;
        check({name, "_beats"}, beats, exp_beats);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, {busy, out_valid, state}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_outputs", {busy, out_valid, out_re, out_im, out_x, out_y, out_eol, out_last, state}, '0);
        @(negedge clk); rst = 1'b0;

`ifndef COORD_SCAN_CENTER_EN
        // Basic frame at full throughput.
        out_ready = 1'b1;
        push_frame(32'hFFC00000, 32'h00200000, 32'h2000);
        start_frame(32'hFFC00000, 32'h00200000, 2'd0);
        frame_end("t1", 12);
        check("t1_re_1_0", cap_re[1], 32'hFFC02000);
        check("t1_im_0_1", cap_im[4], 32'h001FE000);

        // Downstream stalls for the first 5 valid cycles.
        out_ready = 1'b0;
        push_frame(32'hFFC00000, 32'h00200000, 32'h2000);
        start_frame(32'hFFC00000, 32'h00200000, 2'd0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        frame_end("t2", 12);

        // Deepest zoom.
        push_frame(32'h0, 32'h12345678, 32'h80);
        start_frame(32'h0, 32'h12345678, 2'd3);
        frame_end("t3", 12);
        check("t3_re_3_0", cap_re[3], 32'h00000180);

        // Asynchronous reset mid-frame, then a clean restart.
        push_frame(32'h00100000, 32'hFFF00000, 32'h800);
        start_frame(32'h00100000, 32'hFFF00000, 2'd1);
        begin
            int n = 0;
            while (beats < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t4_five_beats", beats, 5);
        end
        #2 rst = 1'b1;
        #1 check("t4_reset_now", {out_valid, busy, state}, 4'b0000);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        push_frame(32'hFFC00000, 32'h00200000, 32'h2000);
        start_frame(32'hFFC00000, 32'h00200000, 2'd0);
        frame_end("t4", 12);

        // start pulses during the frame (including the final transfer) are ignored; re wraps.
        push_frame(32'h7FFFE000, 32'h0, 32'h2000);
        start_frame(32'h7FFFE000, 32'h0, 2'd0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        frame_end("t5", 12);
        repeat (3) @(posedge clk);
        #1 check("t5_stays_idle", {busy, out_valid}, 2'b00);
        check("t5_re_wrap", cap_re[1], 32'h80000000);
`else
        // Centre-origin frame.
        out_ready = 1'b1;
        push_frame(32'hFFFFC000, 32'h00002000, 32'h2000);
        start_frame(32'h0, 32'h0, 2'd0);
        frame_end("t6", 12);
        check("t6_re_0_0", cap_re[0], 32'hFFFFC000);
        check("t6_im_0_0", cap_im[0], 32'h00002000);
        check("t6_re_3_2", cap_re[11], 32'h00002000);
        check("t6_im_3_2", cap_im[11], 32'hFFFFE000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
